// File: rtl/main_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : main_control_fsm
//  Description : Multi-cycle Moore controller that sequences each instruction
//                through fetch/decode/execute/writeback. It drives the
//                datapath selects, the write enables and the ALUOp input of
//                the downstream ALU decoder. Building with ILLEGAL_OP_TRAP_EN
//                defined adds a TRAP state and a sticky illegal_op flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module main_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       PCWrite,
    output logic       illegal_op
);

    localparam logic [6:0] c_op_lw  = 7'b0000011;
    localparam logic [6:0] c_op_sw  = 7'b0100011;
    localparam logic [6:0] c_op_r   = 7'b0110011;
    localparam logic [6:0] c_op_i   = 7'b0010011;
    localparam logic [6:0] c_op_beq = 7'b1100011;
    localparam logic [6:0] c_op_jal = 7'b1101111;

    typedef enum logic [STATE_W-1:0] {
        c_fetch    = STATE_W'(0),
        c_decode   = STATE_W'(1),
        c_memadr   = STATE_W'(2),
        c_memread  = STATE_W'(3),
        c_memwb    = STATE_W'(4),
        c_memwrite = STATE_W'(5),
        c_executer = STATE_W'(6),
        c_executei = STATE_W'(7),
        c_aluwb    = STATE_W'(8),
        c_beq      = STATE_W'(9),
        c_jal      = STATE_W'(10)
`ifdef ILLEGAL_OP_TRAP_EN
        , c_trap   = STATE_W'(11)
`endif
    } state_t;

    state_t     r_state;
    state_t     w_next;
    state_t     w_cur;
    logic [1:0] w_aluop, w_srca, w_srcb, w_ressrc;
    logic       w_adrsrc, w_irwrite, w_regwrite, w_memwrite, w_pcupdate, w_branch;

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_fetch;
        else       r_state <= w_next;
    end

    // While reset is held the outputs present the FETCH selects with all
    // enables masked, so an abandoned instruction can never write anything.
    always_comb begin
        w_cur      = reset ? c_fetch : r_state;
        w_next     = c_fetch;
        w_aluop    = 2'b00;
        w_srca     = 2'b00;
        w_srcb     = 2'b00;
        w_ressrc   = 2'b00;
        w_adrsrc   = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_pcupdate = 1'b0;
        w_branch   = 1'b0;

        case (r_state)
            c_fetch:  w_next = c_decode;
            c_decode: begin
                case (op)
                    c_op_lw, c_op_sw: w_next = c_memadr;
                    c_op_r:           w_next = c_executer;
                    c_op_i:           w_next = c_executei;
                    c_op_beq:         w_next = c_beq;
                    c_op_jal:         w_next = c_jal;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:          w_next = c_trap;
`else
                    default:          w_next = c_fetch;
`endif
                endcase
            end
            // Anything other than lw/sw here means op moved under us; drop it.
            c_memadr: begin
                if (op == c_op_lw)      w_next = c_memread;
                else if (op == c_op_sw) w_next = c_memwrite;
                else                    w_next = c_fetch;
            end
            c_memread:  w_next = c_memwb;
            c_executer: w_next = c_aluwb;
            c_executei: w_next = c_aluwb;
            c_jal:      w_next = c_aluwb;
`ifdef ILLEGAL_OP_TRAP_EN
            c_trap:     w_next = c_trap;
`endif
            default:    w_next = c_fetch;
        endcase

        case (w_cur)
            c_fetch: begin
                w_srcb     = 2'b10;
                w_ressrc   = 2'b10;
                w_irwrite  = 1'b1;
                w_pcupdate = 1'b1;
            end
            c_decode: begin
                w_srca = 2'b01;
                w_srcb = 2'b01;
            end
            c_memadr: begin
                w_srca = 2'b10;
                w_srcb = 2'b01;
            end
            c_memread: w_adrsrc = 1'b1;
            c_memwb: begin
                w_ressrc   = 2'b01;
                w_regwrite = 1'b1;
            end
            c_memwrite: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            c_executer: begin
                w_srca  = 2'b10;
                w_aluop = 2'b10;
            end
            c_executei: begin
                w_srca  = 2'b10;
                w_srcb  = 2'b01;
                w_aluop = 2'b10;
            end
            c_aluwb: w_regwrite = 1'b1;
            c_beq: begin
                w_srca   = 2'b10;
                w_aluop  = 2'b01;
                w_branch = 1'b1;
            end
            c_jal: begin
                w_srca     = 2'b01;
                w_srcb     = 2'b10;
                w_pcupdate = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            c_op_sw:  ImmSrc = 2'b01;
            c_op_beq: ImmSrc = 2'b10;
            c_op_jal: ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    assign ALUOp     = w_aluop;
    assign ALUSrcA   = w_srca;
    assign ALUSrcB   = w_srcb;
    assign ResultSrc = w_ressrc;
    assign AdrSrc    = w_adrsrc;
    assign IRWrite   = w_irwrite  & ~reset;
    assign RegWrite  = w_regwrite & ~reset;
    assign MemWrite  = w_memwrite & ~reset;
    assign PCWrite   = (w_pcupdate | (w_branch & zero)) & ~reset;

`ifdef ILLEGAL_OP_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk) begin
        if (reset)                                      r_illegal <= 1'b0;
        else if (r_state == c_decode && w_next == c_trap) r_illegal <= 1'b1;
    end

    assign illegal_op = r_illegal & ~reset;
`else
    assign illegal_op = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_main_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_main_control_fsm
//  Description : Scoreboard bench for main_control_fsm; the driver queues the
//                hand-derived per-cycle outputs, a monitor compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0;
    logic       zero = 1'b0;
    logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic       AdrSrc, IRWrite, RegWrite, MemWrite, PCWrite, illegal_op;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_q[$];
    string       name_q[$];

    typedef enum int {
        T_RST, T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
        T_EXECR, T_EXECI, T_ALUWB, T_BEQ, T_JAL, T_TRAP
    } tstate_t;

    localparam logic [6:0] c_lw  = 7'b0000011;
    localparam logic [6:0] c_sw  = 7'b0100011;
    localparam logic [6:0] c_r   = 7'b0110011;
    localparam logic [6:0] c_i   = 7'b0010011;
    localparam logic [6:0] c_beq = 7'b1100011;
    localparam logic [6:0] c_jal = 7'b1101111;
    localparam logic [6:0] c_bad = 7'b1111111;

    main_control_fsm #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .PCWrite(PCWrite), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, RegWrite, MemWrite, PCWrite}
    function automatic logic [12:0] state_vec(tstate_t s, logic z);
        case (s)
            T_RST:      return 13'b00_00_10_10_0_0_0_0_0;
            T_FETCH:    return 13'b00_00_10_10_0_1_0_0_1;
            T_DECODE:   return 13'b00_01_01_00_0_0_0_0_0;
            T_MEMADR:   return 13'b00_10_01_00_0_0_0_0_0;
            T_MEMREAD:  return 13'b00_00_00_00_1_0_0_0_0;
            T_MEMWB:    return 13'b00_00_00_01_0_0_1_0_0;
            T_MEMWRITE: return 13'b00_00_00_00_1_0_0_1_0;
            T_EXECR:    return 13'b10_10_00_00_0_0_0_0_0;
            T_EXECI:    return 13'b10_10_01_00_0_0_0_0_0;
            T_ALUWB:    return 13'b00_00_00_00_0_0_1_0_0;
            T_BEQ:      return {12'b01_10_00_00_0_0_0_0, z};
            T_JAL:      return 13'b00_01_10_00_0_0_0_0_1;
            default:    return 13'b0;
        endcase
    endfunction

    function automatic logic [1:0] imm_of(logic [6:0] o);
        case (o)
            c_sw:    return 2'b01;
            c_beq:   return 2'b10;
            c_jal:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic step(input string nm, input tstate_t s, input logic [6:0] o,
                        input logic z = 1'b0, input logic rst = 1'b0,
                        input logic ill = 1'b0);
        logic [12:0] v;
        @(posedge clk);
        #1;
        reset = rst;
        op    = o;
        zero  = z;
        v     = state_vec(s, z);
        exp_q.push_back({v[12:5], imm_of(o), v[4:0], ill});
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        logic [15:0] got, want;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                nm   = name_q.pop_front();
                got  = {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
                        IRWrite, RegWrite, MemWrite, PCWrite, illegal_op};
                n_checks++;
                if (got === want) n_pass++;
                else $display("FAIL %s: got %b want %b", nm, got, want);
            end
        end
    end

    initial begin : driver
        step("rst0", T_RST, 7'b0, 1'b0, 1'b1);
        step("rst1", T_RST, 7'b0, 1'b1, 1'b1);
        // lw, 5 cycles
        step("lw_fetch",  T_FETCH,   c_lw);
        step("lw_decode", T_DECODE,  c_lw);
        step("lw_memadr", T_MEMADR,  c_lw);
        step("lw_memrd",  T_MEMREAD, c_sw);  // op change outside DECODE/MEMADR ignored
        step("lw_memwb",  T_MEMWB,   c_lw);
        // R-type, zero toggled where it must not matter
        step("r_fetch",   T_FETCH,   c_r, 1'b1);
        step("r_decode",  T_DECODE,  c_r, 1'b1);
        step("r_exec",    T_EXECR,   c_r, 1'b1);
        step("r_wb",      T_ALUWB,   c_r);
        // I-type
        step("i_fetch",   T_FETCH,   c_i);
        step("i_decode",  T_DECODE,  c_i);
        step("i_exec",    T_EXECI,   c_i);
        step("i_wb",      T_ALUWB,   c_i);
        // beq taken and not taken
        step("beqt_fetch",  T_FETCH,  c_beq);
        step("beqt_decode", T_DECODE, c_beq);
        step("beqt_beq",    T_BEQ,    c_beq, 1'b1);
        step("beqn_fetch",  T_FETCH,  c_beq);
        step("beqn_decode", T_DECODE, c_beq, 1'b1);
        step("beqn_beq",    T_BEQ,    c_beq, 1'b0);
        // jal
        step("jal_fetch",  T_FETCH,  c_jal);
        step("jal_decode", T_DECODE, c_jal);
        step("jal_jal",    T_JAL,    c_jal);
        step("jal_wb",     T_ALUWB,  c_jal);
        // sw
        step("sw_fetch",  T_FETCH,    c_sw);
        step("sw_decode", T_DECODE,   c_sw);
        step("sw_memadr", T_MEMADR,   c_sw);
        step("sw_memwr",  T_MEMWRITE, c_sw);
        // sw abandoned by reset in MEMADR
        step("swr_fetch",  T_FETCH,  c_sw);
        step("swr_decode", T_DECODE, c_sw);
        step("swr_rst",    T_RST,    c_sw, 1'b0, 1'b1);
        step("swr_after",  T_FETCH,  c_sw);
        step("swr_decode2", T_DECODE, c_sw);
        step("swr_memadr2", T_MEMADR, c_sw);
        step("swr_memwr2",  T_MEMWRITE, c_sw);
        // illegal opcode
        step("bad_fetch",  T_FETCH,  c_bad);
        step("bad_decode", T_DECODE, c_bad);
`ifdef ILLEGAL_OP_TRAP_EN
        step("bad_trap0",  T_TRAP,   c_bad, 1'b0, 1'b0, 1'b1);
        step("bad_trap1",  T_TRAP,   c_lw,  1'b1, 1'b0, 1'b1);
        step("bad_trap2",  T_TRAP,   c_lw,  1'b0, 1'b0, 1'b1);
        step("bad_rst",    T_RST,    c_lw,  1'b0, 1'b1, 1'b0);
`endif
        step("bad_next_fetch", T_FETCH,  c_i);
        step("bad_next_dec",   T_DECODE, c_i);
        step("bad_next_exec",  T_EXECI,  c_i);
        step("bad_next_wb",    T_ALUWB,  c_i);
        step("end_fetch",      T_FETCH,  c_lw);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
